// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit.
//   MULDIV_WIDTH : default operand / result-half width
//   OP_MUL/OP_DIV: encoding of the op input
//   state_t, ST_*: FSM state encoding (IDLE, CALC, FIX, DONE)
// -----------------------------------------------------------------------------
package muldiv_pkg;

   localparam int unsigned MULDIV_WIDTH = 32;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_FIX  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

endpackage : muldiv_pkg

// File: rtl/muldiv_unit_twos_abs.sv
// -----------------------------------------------------------------------------
// twos_abs
// Magnitude and sign of an N-bit value, plus its two's-complement negation.
//   val_i    : input value
//   signed_i : 1 = treat val_i as two's complement, 0 = unsigned
//   mag_o    : |val_i| when signed and negative, otherwise val_i
//   neg_o    : -val_i (unconditional two's-complement negation)
//   sign_o   : 1 when val_i is signed and negative
// -----------------------------------------------------------------------------
module twos_abs #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] val_i,
   input  logic         signed_i,
   output logic [N-1:0] mag_o,
   output logic [N-1:0] neg_o,
   output logic         sign_o
);

   assign neg_o  = ~val_i + {{(N-1){1'b0}}, 1'b1};
   assign sign_o = signed_i & val_i[N-1];
   assign mag_o  = sign_o ? neg_o : val_i;

endmodule : twos_abs

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) unit
// for the execute stage. One result bit per cycle, then one cycle of sign
// correction, then a one-cycle done / HI-LO write strobe.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   start_i     : request an operation (sampled in IDLE only)
//   op_i        : 0 = multiply, 1 = divide
//   is_signed_i : 1 = two's-complement operands
//   a_i, b_i    : multiplicand/dividend, multiplier/divisor
//   flush_i     : abandon in-flight operation, hi/lo untouched
//   busy_o      : operation in flight
//   stall_o     : pipeline stall request (combinational)
//   done_o      : one-cycle result pulse
//   hilo_we_o   : HI/LO write enable (same as done_o)
//   hi_o, lo_o  : product high/low, or remainder/quotient
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             op_i,
   input  logic             is_signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             stall_o,
   output logic             done_o,
   output logic             hilo_we_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 op_q, op_d;
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;
   logic                 dz_q, dz_d;
   logic [WIDTH-1:0]     a_raw_q, a_raw_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic [WIDTH-1:0]     mag_a_s, mag_b_s;
   logic                 sgn_a_s, sgn_b_s;
   logic [WIDTH-1:0]     neg_a_unused, neg_b_unused;
   logic [2*WIDTH-1:0]   fixw_in_s, fixw_neg_s, fixw_mag_unused;
   logic                 fixw_sign_unused;
   logic [WIDTH-1:0]     rem_neg_s, rem_mag_unused;
   logic                 rem_sign_unused;
   logic [WIDTH:0]       mul_sum_s;
   logic [WIDTH:0]       rem_sh_s;
   logic [WIDTH:0]       diff_s;
   logic                 flip_s;

   twos_abs #(.N(WIDTH)) u_abs_a (
      .val_i    (a_i),
      .signed_i (is_signed_i),
      .mag_o    (mag_a_s),
      .neg_o    (neg_a_unused),
      .sign_o   (sgn_a_s)
   );

   twos_abs #(.N(WIDTH)) u_abs_b (
      .val_i    (b_i),
      .signed_i (is_signed_i),
      .mag_o    (mag_b_s),
      .neg_o    (neg_b_unused),
      .sign_o   (sgn_b_s)
   );

   // Wide negation: full 2*WIDTH product, or zero-extended quotient.
   twos_abs #(.N(2*WIDTH)) u_neg_wide (
      .val_i    (fixw_in_s),
      .signed_i (1'b0),
      .mag_o    (fixw_mag_unused),
      .neg_o    (fixw_neg_s),
      .sign_o   (fixw_sign_unused)
   );

   twos_abs #(.N(WIDTH)) u_neg_rem (
      .val_i    (rem_q),
      .signed_i (1'b0),
      .mag_o    (rem_mag_unused),
      .neg_o    (rem_neg_s),
      .sign_o   (rem_sign_unused)
   );

   // Signs were captured already gated by is_signed, so flip is 0 in unsigned mode.
   assign flip_s    = sign_a_q ^ sign_b_q;
   assign fixw_in_s = (op_q == OP_DIV) ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;

   // Multiply step: add multiplicand into the upper half when the low bit is set.
   assign mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

   // Divide step: shift next dividend bit into the (WIDTH+1)-bit partial remainder.
   assign rem_sh_s  = {rem_q, acc_q[WIDTH-1]};
   assign diff_s    = rem_sh_s - {1'b0, opnd_q};

   // Next-state and datapath update for the FSM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      dz_d     = dz_q;
      a_raw_d  = a_raw_q;
      opnd_d   = opnd_q;
      rem_d    = rem_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  op_d     = op_i;
                  sign_a_d = sgn_a_s;
                  sign_b_d = sgn_b_s;
                  a_raw_d  = a_i;
                  cnt_d    = CNT_W'(WIDTH - 1);
                  rem_d    = {WIDTH{1'b0}};
                  dz_d     = (op_i == OP_DIV) && (b_i == {WIDTH{1'b0}});
                  if (op_i == OP_DIV) begin
                     acc_d  = {{WIDTH{1'b0}}, mag_a_s};
                     opnd_d = mag_b_s;
                  end else begin
                     acc_d  = {{WIDTH{1'b0}}, mag_b_s};
                     opnd_d = mag_a_s;
                  end
                  // Divide by zero skips the iterations entirely.
                  state_d = ((op_i == OP_DIV) && (b_i == {WIDTH{1'b0}})) ? ST_FIX : ST_CALC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CALC: begin
               if (op_q == OP_DIV) begin
                  // Restoring: keep the difference only if it did not go negative.
                  if (!diff_s[WIDTH]) begin
                     rem_d = diff_s[WIDTH-1:0];
                     acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_d = rem_sh_s[WIDTH-1:0];
                     acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
               end
               if (cnt_q == {CNT_W{1'b0}}) begin
                  state_d = ST_FIX;
               end else begin
                  cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_FIX: begin
               state_d = ST_DONE;
               if (dz_q) begin
                  hi_d = a_raw_q;
                  lo_d = {WIDTH{1'b1}};
               end else if (op_q == OP_DIV) begin
                  lo_d = flip_s   ? fixw_neg_s[WIDTH-1:0] : acc_q[WIDTH-1:0];
                  hi_d = sign_a_q ? rem_neg_s : rem_q;
               end else begin
                  {hi_d, lo_d} = flip_s ? fixw_neg_s : acc_q;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         op_q     <= OP_MUL;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         dz_q     <= 1'b0;
         a_raw_q  <= {WIDTH{1'b0}};
         opnd_q   <= {WIDTH{1'b0}};
         rem_q    <= {WIDTH{1'b0}};
         acc_q    <= {(2*WIDTH){1'b0}};
         hi_q     <= {WIDTH{1'b0}};
         lo_q     <= {WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         dz_q     <= dz_d;
         a_raw_q  <= a_raw_d;
         opnd_q   <= opnd_d;
         rem_q    <= rem_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy_o    = (state_q != ST_IDLE);
   assign done_o    = (state_q == ST_DONE);
   assign hilo_we_o = done_o;
   assign stall_o   = (start_i & (state_q == ST_IDLE) & ~flush_i) | (busy_o & ~done_o);
   assign hi_o      = hi_q;
   assign lo_o      = lo_q;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed-vector bench for muldiv_unit (WIDTH=32). Inputs are driven and
// outputs sampled on the falling edge; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam int W = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic          op_i;
   logic          is_signed_i;
   logic [W-1:0]  a_i;
   logic [W-1:0]  b_i;
   logic          flush_i;
   logic          busy_o;
   logic          stall_o;
   logic          done_o;
   logic          hilo_we_o;
   logic [W-1:0]  hi_o;
   logic [W-1:0]  lo_o;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .op_i        (op_i),
      .is_signed_i (is_signed_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .flush_i     (flush_i),
      .busy_o      (busy_o),
      .stall_o     (stall_o),
      .done_o      (done_o),
      .hilo_we_o   (hilo_we_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   // 10-unit clock period.
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch one operation, wait for done (bounded), check latency and result.
   task automatic run_op(input string tag, input logic op, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input int exp_lat);
      int cyc;
      int busy_low;
      start_i     = 1'b1;
      op_i        = op;
      is_signed_i = sgn;
      a_i         = a;
      b_i         = b;
      #1;
      check_eq({tag, "_stall_start"}, {63'd0, stall_o}, 64'd1);
      @(negedge clk_i);
      start_i  = 1'b0;
      cyc      = 1;
      busy_low = 0;
      while (!done_o && cyc < 200) begin
         if (!busy_o) busy_low++;
         if (!stall_o) busy_low++;
         @(negedge clk_i);
         cyc++;
      end
      if (!busy_o) busy_low++;
      check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
      check_eq({tag, "_busy_stall"}, 64'(busy_low), 64'd0);
      check_eq({tag, "_hilo_we"}, {63'd0, hilo_we_o}, 64'd1);
      check_eq({tag, "_hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
      check_eq({tag, "_lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
      @(negedge clk_i);
      check_eq({tag, "_idle_after"}, {62'd0, busy_o, done_o}, 64'd0);
   endtask

   // Count done pulses over a window of cycles.
   task automatic count_done(input int ncyc, output int ndone);
      ndone = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk_i);
         if (done_o) ndone++;
      end
   endtask

   initial begin
      int nd;
      rst_i       = 1'b1;
      start_i     = 1'b0;
      op_i        = 1'b0;
      is_signed_i = 1'b0;
      a_i         = '0;
      b_i         = '0;
      flush_i     = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      check_eq("reset_ctrl", {60'd0, busy_o, done_o, hilo_we_o, stall_o}, 64'd0);
      check_eq("reset_hilo", {hi_o, lo_o}, 64'd0);

      // Multiplies.
      run_op("mulu_ffff_x2", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 34);
      run_op("mul_m3_x5",    1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34);
      run_op("mulu_m3_x5",   1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 34);

      // Divides.
      run_op("div_m7_2",     1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
      run_op("divu_100_7",   1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 34);
      run_op("div_ovf",      1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);

      // Divide by zero, with a stray start pulsed while busy.
      start_i = 1'b1; op_i = 1'b1; is_signed_i = 1'b1; a_i = 32'd5; b_i = 32'd0;
      @(negedge clk_i);
      a_i = 32'd77; b_i = 32'd3; op_i = 1'b0;   // start still high while busy
      @(negedge clk_i);
      start_i = 1'b0;
      check_eq("dz_done_at_2", {62'd0, done_o, hilo_we_o}, 64'd3);
      check_eq("dz_hi", {32'd0, hi_o}, 64'd5);
      check_eq("dz_lo", {32'd0, lo_o}, 64'hFFFF_FFFF);
      count_done(40, nd);
      check_eq("dz_single_done", 64'(nd), 64'd0);

      // Flush a divide at cycle 10.
      start_i = 1'b1; op_i = 1'b1; is_signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (9) @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      check_eq("flush_busy", {63'd0, busy_o}, 64'd0);
      count_done(40, nd);
      check_eq("flush_no_done", 64'(nd), 64'd0);
      check_eq("flush_hilo_kept", {hi_o, lo_o}, {32'd5, 32'hFFFF_FFFF});
      run_op("divu_after_flush", 1'b1, 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 34);

      // Reset mid-multiply at cycle 20.
      start_i = 1'b1; op_i = 1'b0; is_signed_i = 1'b0; a_i = 32'd3; b_i = 32'd4;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (19) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check_eq("rst_ctrl", {60'd0, busy_o, done_o, hilo_we_o, stall_o}, 64'd0);
      check_eq("rst_hilo", {hi_o, lo_o}, 64'd0);
      run_op("mulu_after_rst", 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 34);

      // flush and start together in IDLE: nothing accepted.
      start_i = 1'b1; flush_i = 1'b1; op_i = 1'b0; a_i = 32'd9; b_i = 32'd9;
      #1;
      check_eq("fs_stall", {63'd0, stall_o}, 64'd0);
      @(negedge clk_i);
      start_i = 1'b0; flush_i = 1'b0;
      check_eq("fs_busy", {63'd0, busy_o}, 64'd0);
      count_done(40, nd);
      check_eq("fs_no_done", 64'(nd), 64'd0);
      check_eq("fs_hilo_kept", {hi_o, lo_o}, {32'd0, 32'd42});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_muldiv_unit
